// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: MemOp codes, LSU fault codes, LSU state encoding,
// and the request legality/alignment check.
package riscv_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_BU = 3'b001;
  localparam logic [2:0] MEMOP_H  = 3'b010;
  localparam logic [2:0] MEMOP_HU = 3'b011;
  localparam logic [2:0] MEMOP_W  = 3'b100;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_t;

  // Illegal encodings win over misalignment; unsigned codes are load-only.
  function automatic logic [1:0] lsu_check(input logic wr, input logic rd,
                                           input logic [2:0] op, input logic [1:0] a);
    logic       legal;
    logic [1:0] res;
    if (wr && rd)  legal = 1'b0;
    else if (wr)   legal = (op == MEMOP_B) || (op == MEMOP_H) || (op == MEMOP_W);
    else           legal = (op <= MEMOP_W);
    res = FAULT_NONE;
    if (!legal)                                         res = FAULT_ILLEGAL;
    else if ((op == MEMOP_H || op == MEMOP_HU) && a[0]) res = FAULT_MISALIGN;
    else if (op == MEMOP_W && a != 2'b00)              res = FAULT_MISALIGN;
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables / replicated write data, and
// load lane selection with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[i_addr_lo];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_wdata;
    o_load_data = i_rdata;
    case (i_memop)
      MEMOP_B, MEMOP_BU: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_wdata[7:0]}};
        o_load_data = {{24{w_byte[7] & (i_memop == MEMOP_B)}}, w_byte};
      end
      MEMOP_H, MEMOP_HU: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata     = {2{i_wdata[15:0]}};
        o_load_data = {{16{w_half[15] & (i_memop == MEMOP_H)}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: accept one request, drive a handshaked word
// bus with timeout, and return an extended load result with a fault code.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [2:0]  MemOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault
);

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic [2:0]  r_memop, w_memop_next;
  logic [1:0]  r_addr_lo, w_addr_lo_next;
  logic        r_is_load, w_is_load_next;
  logic        r_in_ready, w_in_ready_next;
  logic        r_mem_req, w_mem_req_next;
  logic        r_mem_we, w_mem_we_next;
  logic [3:0]  r_mem_be, w_mem_be_next;
  logic [31:0] r_mem_addr, w_mem_addr_next;
  logic [31:0] r_mem_wdata, w_mem_wdata_next;
  logic        r_done, w_done_next;
  logic [31:0] r_load_data, w_load_data_next;
  logic [1:0]  r_fault, w_fault_next;

  logic [1:0]  w_chk;
  logic [2:0]  w_sel_op;
  logic [1:0]  w_sel_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_chk = lsu_check(MemWr, MemRd, MemOp, addr[1:0]);

  // One aligner serves both directions: live inputs at accept, captured op later.
  assign w_sel_op = (r_state == LSU_IDLE) ? MemOp : r_memop;
  assign w_sel_lo = (r_state == LSU_IDLE) ? addr[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_memop     (w_sel_op),
    .i_addr_lo   (w_sel_lo),
    .i_wdata     (wdata),
    .i_rdata     (mem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load)
  );

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_memop_next     = r_memop;
    w_addr_lo_next   = r_addr_lo;
    w_is_load_next   = r_is_load;
    w_in_ready_next  = r_in_ready;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_be_next    = r_mem_be;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_done_next      = r_done;
    w_load_data_next = r_load_data;
    w_fault_next     = r_fault;
    case (r_state)
      LSU_IDLE: begin
        if (in_valid) begin
          w_memop_next   = MemOp;
          w_addr_lo_next = addr[1:0];
          w_is_load_next = MemRd;
          if (MemWr || MemRd) begin
            w_in_ready_next = 1'b0;
            if (w_chk != FAULT_NONE) begin
              w_state_next     = LSU_RESP;
              w_done_next      = 1'b1;
              w_fault_next     = w_chk;
              w_load_data_next = '0;
            end else begin
              w_state_next     = LSU_ACCESS;
              w_cnt_next       = '0;
              w_mem_req_next   = 1'b1;
              w_mem_we_next    = MemWr;
              w_mem_be_next    = MemWr ? w_be : 4'b1111;
              w_mem_addr_next  = {addr[31:2], 2'b00};
              w_mem_wdata_next = MemWr ? w_wdata : '0;
            end
          end
        end
      end
      LSU_ACCESS: begin
        // An ack in the final counted cycle still completes the access.
        if (mem_ack) begin
          w_state_next     = LSU_RESP;
          w_mem_req_next   = 1'b0;
          w_mem_we_next    = 1'b0;
          w_done_next      = 1'b1;
          w_fault_next     = FAULT_NONE;
          w_load_data_next = r_is_load ? w_load : '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_next     = LSU_RESP;
          w_mem_req_next   = 1'b0;
          w_mem_we_next    = 1'b0;
          w_done_next      = 1'b1;
          w_fault_next     = FAULT_TIMEOUT;
          w_load_data_next = '0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      LSU_RESP: begin
        w_state_next     = LSU_IDLE;
        w_in_ready_next  = 1'b1;
        w_done_next      = 1'b0;
        w_fault_next     = FAULT_NONE;
        w_load_data_next = '0;
      end
      default: begin
        w_state_next     = LSU_IDLE;
        w_in_ready_next  = 1'b1;
        w_mem_req_next   = 1'b0;
        w_mem_we_next    = 1'b0;
        w_done_next      = 1'b0;
        w_fault_next     = FAULT_NONE;
        w_load_data_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LSU_IDLE;
      r_cnt       <= '0;
      r_memop     <= '0;
      r_addr_lo   <= '0;
      r_is_load   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_load_data <= '0;
      r_fault     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_memop     <= w_memop_next;
      r_addr_lo   <= w_addr_lo_next;
      r_is_load   <= w_is_load_next;
      r_in_ready  <= w_in_ready_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_be    <= w_mem_be_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_done      <= w_done_next;
      r_load_data <= w_load_data_next;
      r_fault     <= w_fault_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign load_data = r_load_data;
  assign fault     = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random accesses against an
// arithmetic reference model, plus timeout, late-ack and mid-access reset cases.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        MemWr = 1'b0;
  logic        MemRd = 1'b0;
  logic [2:0]  MemOp = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  fault;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .MemWr(MemWr), .MemRd(MemRd), .MemOp(MemOp), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .load_data(load_data), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  done_cyc;
    logic [7:0]  req_cycles;
    logic [31:0] bus_addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] bwdata;
    logic [31:0] load;
    logic [1:0]  fault;
  } exp_t;

  typedef struct packed {
    exp_t        e;
    logic        unstable;
    logic        ready_before;
    logic        ready_after;
    logic        done_after;
  } res_t;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdw;
    logic [7:0]  waits;
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;
  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Reference model: sizes, remainders, shifts and multiplicative replication.
  function automatic exp_t model(input logic wr, input logic rd, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdw, input int waits);
    exp_t e;
    int unsigned size, off;
    logic legal;
    logic [31:0] v;
    e = '0;
    case (op)
      3'd0, 3'd1: size = 1;
      3'd2, 3'd3: size = 2;
      3'd4:       size = 4;
      default:    size = 0;
    endcase
    if (wr && rd) legal = 1'b0;
    else if (wr)  legal = (op == 3'd0 || op == 3'd2 || op == 3'd4);
    else          legal = (size != 0);
    off = a % 4;
    if (!legal || (a % size) != 0) begin
      e.fault    = legal ? 2'd1 : 2'd3;
      e.done_cyc = 8'd1;
      return e;
    end
    e.bus_addr = a - off;
    e.we       = wr;
    if (wr) begin
      e.be = 4'(((1 << size) - 1) << off);
      if (size == 1)      e.bwdata = {24'd0, wd[7:0]} * 32'h0101_0101;
      else if (size == 2) e.bwdata = {16'd0, wd[15:0]} * 32'h0001_0001;
      else                e.bwdata = wd;
    end else begin
      e.be = 4'hF;
    end
    if (waits >= TO) begin
      e.fault      = 2'd2;
      e.done_cyc   = 8'(TO + 1);
      e.req_cycles = 8'(TO);
    end else begin
      e.done_cyc   = 8'(waits + 2);
      e.req_cycles = 8'(waits + 1);
      if (rd) begin
        v = rdw >> (8 * off);
        if (size == 1) begin
          v = v % 256;
          if (op == 3'd0 && v >= 128) v = v - 256;
        end else if (size == 2) begin
          v = v % 65536;
          if (op == 3'd2 && v >= 32768) v = v - 65536;
        end
        e.load = v;
      end
    end
    return e;
  endfunction

  task automatic run(input logic wr, input logic rd, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rdw, input int waits, output res_t r);
    int cyc;
    int reqc;
    r = '0;
    r.e.done_cyc = 8'hFF;
    r.ready_before = in_ready;
    in_valid = 1'b1; MemWr = wr; MemRd = rd; MemOp = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; MemWr = 1'b0; MemRd = 1'b0; wdata = $urandom; addr = $urandom;
    cyc = 1; reqc = 0;
    while (cyc < 20) begin
      if (done) begin
        r.e.done_cyc = 8'(cyc);
        r.e.load     = load_data;
        r.e.fault    = fault;
        break;
      end
      if (mem_req) begin
        if (reqc == 0) begin
          r.e.bus_addr = mem_addr; r.e.be = mem_be; r.e.we = mem_we; r.e.bwdata = mem_wdata;
        end else if (mem_addr !== r.e.bus_addr || mem_be !== r.e.be ||
                     mem_we !== r.e.we || mem_wdata !== r.e.bwdata) begin
          r.unstable = 1'b1;
        end
        reqc++;
        if (reqc > waits) begin mem_ack = 1'b1; mem_rdata = rdw; end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      cyc++;
    end
    r.e.req_cycles = 8'(reqc);
    @(posedge clk); #1;
    r.ready_after = in_ready;
    r.done_after  = done;
    n_txn++;
    $display("txn %0d: wr=%0b rd=%0b op=%0d addr=%08h waits=%0d done@%0d fault=%0d load=%08h",
             n_txn, wr, rd, op, a, waits, r.e.done_cyc, r.e.fault, r.e.load);
  endtask

  task automatic compare(input string nm, input res_t r, input exp_t e);
    check({nm, ".ready_before"}, 32'(r.ready_before), 32'd1);
    check({nm, ".done_cyc"},     32'(r.e.done_cyc),   32'(e.done_cyc));
    check({nm, ".fault"},        32'(r.e.fault),      32'(e.fault));
    check({nm, ".load"},         r.e.load,            e.load);
    check({nm, ".req_cycles"},   32'(r.e.req_cycles), 32'(e.req_cycles));
    if (e.req_cycles != 0) begin
      check({nm, ".mem_addr"},  r.e.bus_addr,      e.bus_addr);
      check({nm, ".mem_be"},    32'(r.e.be),       32'(e.be));
      check({nm, ".mem_we"},    32'(r.e.we),       32'(e.we));
      check({nm, ".mem_wdata"}, r.e.bwdata,        e.bwdata);
      check({nm, ".stable"},    32'(r.unstable),   32'd0);
    end
    check({nm, ".done_1cyc"},   32'(r.done_after),  32'd0);
    check({nm, ".ready_after"}, 32'(r.ready_after), 32'd1);
  endtask

  task automatic add_vec(input logic wr, input logic rd, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                         input int waits, input int dcyc, input int reqc, input logic [3:0] be,
                         input logic [31:0] bwd, input logic [31:0] ld, input logic [1:0] f);
    vec_t v;
    v.wr = wr; v.rd = rd; v.op = op; v.a = a; v.wd = wd; v.rdw = rdw; v.waits = 8'(waits);
    v.e.done_cyc = 8'(dcyc); v.e.req_cycles = 8'(reqc);
    v.e.bus_addr = (reqc != 0) ? {a[31:2], 2'b00} : 32'd0;
    v.e.be = be; v.e.we = wr; v.e.bwdata = bwd; v.e.load = ld; v.e.fault = f;
    vq.push_back(v);
  endtask

  initial begin
    res_t r;
    exp_t e;
    logic wr, rd;
    logic [2:0] op;
    logic [31:0] a;
    int waits;

    // Directed vectors with hand-derived expectations.
    add_vec(1, 0, 3'd0, 32'h1003, 32'hAABBCCDD, 32'h0, 2, 4, 3, 4'b1000, 32'hDDDDDDDD, 32'h0, 2'd0);
    add_vec(0, 1, 3'd0, 32'h2001, 32'h0, 32'h80FF7F01, 0, 2, 1, 4'hF, 32'h0, 32'h0000007F, 2'd0);
    add_vec(0, 1, 3'd0, 32'h2002, 32'h0, 32'h80FF7F01, 0, 2, 1, 4'hF, 32'h0, 32'hFFFFFFFF, 2'd0);
    add_vec(0, 1, 3'd1, 32'h2003, 32'h0, 32'h80FF7F01, 1, 3, 2, 4'hF, 32'h0, 32'h00000080, 2'd0);
    add_vec(0, 1, 3'd2, 32'h2002, 32'h0, 32'h80FF7F01, 0, 2, 1, 4'hF, 32'h0, 32'hFFFF80FF, 2'd0);
    add_vec(0, 1, 3'd3, 32'h2002, 32'h0, 32'h80FF7F01, 0, 2, 1, 4'hF, 32'h0, 32'h000080FF, 2'd0);
    add_vec(0, 1, 3'd4, 32'h2000, 32'h0, 32'h80FF7F01, 0, 2, 1, 4'hF, 32'h0, 32'h80FF7F01, 2'd0);
    add_vec(0, 1, 3'd4, 32'h3002, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 2'd1);
    add_vec(1, 0, 3'd1, 32'h3000, 32'h12345678, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 2'd3);
    add_vec(1, 0, 3'd2, 32'h0012, 32'h12345678, 32'h0, 0, 2, 1, 4'b1100, 32'h56785678, 32'h0, 2'd0);
    add_vec(1, 1, 3'd4, 32'h0040, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 2'd3);
    add_vec(0, 1, 3'd7, 32'h0003, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 2'd3);
    add_vec(0, 1, 3'd4, 32'h0044, 32'h0, 32'hCAFEF00D, TO - 1, TO + 1, TO, 4'hF, 32'h0, 32'hCAFEF00D, 2'd0);
    add_vec(1, 0, 3'd4, 32'h0048, 32'h01020304, 32'h0, 9, TO + 1, TO, 4'hF, 32'h01020304, 32'h0, 2'd2);

    // Reset values while reset is held.
    #12;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.mem_req",   32'(mem_req),   32'd0);
    check("rst.mem_we",    32'(mem_we),    32'd0);
    check("rst.mem_be",    32'(mem_be),    32'd0);
    check("rst.mem_addr",  mem_addr,       32'd0);
    check("rst.mem_wdata", mem_wdata,      32'd0);
    check("rst.done",      32'(done),      32'd0);
    check("rst.load_data", load_data,      32'd0);
    check("rst.fault",     32'(fault),     32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      run(vq[i].wr, vq[i].rd, vq[i].op, vq[i].a, vq[i].wd, vq[i].rdw, int'(vq[i].waits), r);
      compare($sformatf("vec%0d", i), r, vq[i].e);
    end

    // No-op request: accepted, nothing happens.
    in_valid = 1'b1; MemWr = 1'b0; MemRd = 1'b0; MemOp = 3'd4; addr = 32'h100;
    @(posedge clk); #1; in_valid = 1'b0;
    check("noop.in_ready", 32'(in_ready), 32'd1);
    check("noop.mem_req",  32'(mem_req),  32'd0);
    check("noop.done",     32'(done),     32'd0);

    // Timeout then a late ack in IDLE.
    run(0, 1, 3'd4, 32'h0080, 32'h0, 32'h11112222, 99, r);
    compare("timeout", r, model(0, 1, 3'd4, 32'h0080, 32'h0, 32'h11112222, 99));
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack.done",     32'(done),     32'd0);
    check("late_ack.mem_req",  32'(mem_req),  32'd0);
    check("late_ack.in_ready", 32'(in_ready), 32'd1);

    // Randomized accesses against the model.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin wr = 1'b0; rd = 1'b1; end
        3, 4:    begin wr = 1'b1; rd = 1'b0; end
        default: begin wr = 1'b1; rd = 1'b1; end
      endcase
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) op = wr ? 3'(2 * $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = (op >= 3'd4) ? (a & ~32'd3) : (op >= 3'd2) ? (a & ~32'd1) : a;
      waits = $urandom_range(0, 5);
      begin
        logic [31:0] wd, rdw;
        wd = $urandom; rdw = $urandom;
        e = model(wr, rd, op, a, wd, rdw, waits);
        run(wr, rd, op, a, wd, rdw, waits, r);
        compare($sformatf("rand%0d", k), r, e);
      end
    end

    // Reset in the middle of an access.
    in_valid = 1'b1; MemWr = 1'b0; MemRd = 1'b1; MemOp = 3'd4; addr = 32'h0100;
    @(posedge clk); #1; in_valid = 1'b0; MemRd = 1'b0;
    @(posedge clk); #1;
    check("mid_rst.req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst.req_async",  32'(mem_req),  32'd0);
    check("mid_rst.done",       32'(done),     32'd0);
    check("mid_rst.in_ready",   32'(in_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ack.done", 32'(done),    32'd0);
    check("post_rst_ack.req",  32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    run(0, 1, 3'd4, 32'h0, 32'h0, 32'h76543210, 0, r);
    compare("after_rst", r, model(0, 1, 3'd4, 32'h0, 32'h0, 32'h76543210, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RV32I core. It sits downstream of `control_unit`: it consumes `MemWr`, `MemtoReg` (load request), `MemOp`, the ALU-computed effective address and the rs2 store data. It performs one byte, half or word access over a word-wide, handshaked data-memory port. Load data is returned lane-selected and sign- or zero-extended, with alignment, encoding and bus-timeout faults reported.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles to wait for `mem_ack` after `mem_req` rises. Range 1..255. Held in an 8-bit counter.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: access request from the execute stage.
- `in_ready` out 1: the LSU can accept a request.
- `MemWr` in 1: 1 = store.
- `MemRd` in 1: 1 = load. Driven from `control_unit` MemtoReg.
- `MemOp` in 3: 000 byte signed, 001 byte unsigned, 010 half signed, 011 half unsigned, 100 word.
- `addr` in 32: byte effective address.
- `wdata` in 32: store data. Low bits are used.
- `mem_req` out 1: bus request, held until ack or timeout.
- `mem_we` out 1: bus write enable.
- `mem_be` out 4: byte enables. All 1s on loads.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus completion. For loads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: bus read word.
- `done` out 1: one-cycle completion pulse.
- `load_data` out 32: extended load result. Valid while `done`=1.
- `fault` out 2: 00 none, 01 misaligned, 10 bus timeout, 11 illegal MemOp. Valid while `done`=1.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - ACCESS: `mem_req`=1.
  - RESP: `done`=1.
- IDLE transitions, on `in_valid`=1 (request accepted and captured into registers):
  - `MemWr`=`MemRd`=0: the request is accepted and stays in IDLE with no effect.
  - Legal and aligned: → ACCESS.
  - Misaligned or illegal: → RESP with a fault. The bus is never touched.
- Both `MemWr` and `MemRd` set is treated as illegal (fault 11).
- Legality:
  - Loads accept MemOp 000/001/010/011/100.
  - Stores accept 000/010/100.
  - Any other code gives fault 11. Illegal takes priority over misaligned.
- Alignment:
  - Half access needs `addr[0]`=0.
  - Word access needs `addr[1:0]`=00.
  - A violation gives fault 01.
- Store lanes:
  - Byte: `mem_be` = 0001 << `addr[1:0]`; `mem_wdata` = `wdata[7:0]` replicated ×4.
  - Half: `mem_be` = 0011 or 1100 by `addr[1]`; `mem_wdata` = `wdata[15:0]` replicated ×2.
  - Word: `mem_be` = 1111; `mem_wdata` = `wdata`.
- Load extraction, from the captured `mem_rdata`:
  - Byte: lane `addr[1:0]`.
  - Half: lane `addr[1]`.
  - Word: the full 32 bits.
  - Extension: signed codes sign-extend from bit 7/15; unsigned codes zero-extend.
- ACCESS transitions:
  - `mem_ack`=1: capture `mem_rdata` → RESP, fault 00.
  - Timeout counter reaches `TIMEOUT` without ack: → RESP, fault 10, `load_data` = 0.
- RESP: `done`=1 for exactly one cycle, then → IDLE.
- `load_data` is 0 for stores and for all faults.

## Timing
- Reset values: state IDLE, `in_ready`=1. The following are all 0:
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`
  - `done`, `load_data`, `fault`
  - timeout counter
- All outputs are registered.
- Bus outputs are stable for the whole of ACCESS.
- Latency, aligned access with ack in the first ACCESS cycle:
  - Accept at cycle 0.
  - `mem_req` high in cycle 1.
  - `done` in cycle 2.
  - `in_ready` high again in cycle 3.
- Each extra wait cycle adds 1.
- Fault on accept: `done` in cycle 1, no `mem_req`.
- Timeout: the counter starts at 0 in the first ACCESS cycle and increments each cycle without ack.
  - Fault 10 is taken in the cycle where the count equals `TIMEOUT`−1 and ack is absent.
  - `mem_req` is therefore high for exactly `TIMEOUT` cycles.
- Ack in the same cycle the count hits its limit: the ack wins and the access succeeds.
- `mem_ack` outside ACCESS is ignored, including a late ack after a timeout.
- `rst` mid-access: `mem_req` and `done` drop asynchronously and the FSM returns to IDLE. The pending request is lost. An ack arriving after reset is ignored.
- `in_valid` while `in_ready`=0 is not accepted. The upstream stage holds its request.

## Structure
- Shared package `riscv_pkg` holds:
  - MemOp codes: MEMOP_B, MEMOP_BU, MEMOP_H, MEMOP_HU, MEMOP_W.
  - Fault codes: FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT, FAULT_ILLEGAL.
  - LSU state encoding: LSU_IDLE, LSU_ACCESS, LSU_RESP.
- Sub-module `lsu_align` (combinational) does store lane/be generation and load lane select/extension.
- `load_store_unit` holds the FSM, the capture registers and the timeout counter.

## Test plan
- Store byte, `addr`=0x1003, `wdata`=0xAABBCCDD, MemOp 000, ack after 2 waits:
  - Bus: `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xDDDDDDDD, `mem_we`=1.
  - Response: `done` 4 cycles after accept, fault 00.
- Load byte, `mem_rdata`=0x80FF7F01:
  - `addr`=0x2001, MemOp 000 → `load_data`=0x0000007F.
  - `addr`=0x2002, MemOp 000 → 0xFFFFFFFF.
  - `addr`=0x2003, MemOp 001 → 0x00000080.
- Load half `addr`=0x2002 with MemOp 010 → 0xFFFF80FF; with MemOp 011 → 0x000080FF. Word load at `addr`=0x2000 → 0x80FF7F01.
- Faults:
  - Word load at `addr`=0x3002 → fault 01 in cycle 1, `mem_req` never high.
  - Store with MemOp 001 → fault 11.
- `TIMEOUT`=4, no ack → `mem_req` high exactly 4 cycles, then `done` with fault 10. A late ack injected in IDLE causes no effect.
- Reset mid-access: assert `rst` during ACCESS → `mem_req` drops immediately. Then a subsequent word load at 0x0 completes with 2-cycle latency.
